// File: rtl/seven_seg_decoder.sv
// Registered 4-bit code to 7-segment + DP decoder for the shared segment bus; 1-cycle latency,
// no handshake: every edge captures the current inputs, lamp test over blank over decode.
module seven_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic       dp_en,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [7:0] digit_show
);

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;  // {g,f,e,d,c,b,a}
  } seg_bus_t;

  localparam seg_bus_t BUS_DARK = '{dp: 1'b1, seg: 7'h7F};
  localparam seg_bus_t BUS_LIT  = '{dp: 1'b0, seg: 7'h00};

  logic [6:0] seg_al;
  seg_bus_t   bus_al;
  logic [7:0] bus_out;

  // Glyph table is held active-low; polarity is applied once at the register input.
  always_comb begin
    seg_al = 7'h7F;
    case (num)
      4'd0:    seg_al = 7'h40;
      4'd1:    seg_al = 7'h79;
      4'd2:    seg_al = 7'h24;
      4'd3:    seg_al = 7'h30;
      4'd4:    seg_al = 7'h19;
      4'd5:    seg_al = 7'h12;
      4'd6:    seg_al = 7'h02;
      4'd7:    seg_al = 7'h78;
      4'd8:    seg_al = 7'h00;
      4'd9:    seg_al = 7'h10;
      4'd10:   seg_al = 7'h7F;
      4'd11:   seg_al = 7'h3F;
      4'd12:   seg_al = 7'h06;
      4'd13:   seg_al = 7'h2F;
      4'd14:   seg_al = 7'h23;
      default: seg_al = 7'h7F;
    endcase
  end

  always_comb begin
    bus_al = '{dp: ~dp_en, seg: seg_al};
    if (lamp_test) begin
      bus_al = BUS_LIT;
    end else if (blank) begin
      bus_al = BUS_DARK;
    end
  end

  assign bus_out = ACTIVE_LOW ? bus_al : ~bus_al;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_show <= ACTIVE_LOW ? BUS_DARK : ~BUS_DARK;
    end else begin
      digit_show <= bus_out;
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Drives an active-low and an active-high decoder from the same stimulus and scores both.
module tb_seven_seg_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] num;
  logic       dp_en;
  logic       blank;
  logic       lamp_test;
  logic [7:0] show_al;
  logic [7:0] show_ah;

  always #5 clk = ~clk;

  seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .num(num), .dp_en(dp_en), .blank(blank),
    .lamp_test(lamp_test), .digit_show(show_al)
  );

  seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .num(num), .dp_en(dp_en), .blank(blank),
    .lamp_test(lamp_test), .digit_show(show_ah)
  );

  typedef struct {
    logic       rst;
    logic [3:0] num;
    logic       dp_en;
    logic       blank;
    logic       lamp_test;
    logic [7:0] exp;     // active-low expectation
  } vec_t;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  exp;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[32];
  int   n_vec    = 0;
  int   total    = 0;
  int   pass_cnt = 0;

  task automatic add(input logic r, input logic [3:0] n, input logic d,
                     input logic b, input logic l, input logic [7:0] e);
    tbl[n_vec] = '{rst: r, num: n, dp_en: d, blank: b, lamp_test: l, exp: e};
    n_vec++;
  endtask

  // Drive one input vector for the next rising edge and record what it must produce.
  task automatic apply(input logic r, input logic [3:0] n, input logic d,
                       input logic b, input logic l, input logic [7:0] e, input int id);
    @(negedge clk);
    rst       = r;
    num       = n;
    dp_en     = d;
    blank     = b;
    lamp_test = l;
    sb.push_back('{id: id[15:0], exp: e});
  endtask

  task automatic check(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s vec%0d: got %02h, expected %02h", name, id, act, exp);
    end
  endtask

  // Scoreboard: each recorded vector is compared just after the edge that captured it.
  initial begin
    sb_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        item = sb.pop_front();
        check("active_low", int'(item.id), show_al, item.exp);
        check("active_high", int'(item.id), show_ah, ~item.exp);
      end
    end
  end

  initial begin
    logic [7:0] sweep [16];
    int         wait_cnt;

    rst = 1'b1; num = 4'd0; dp_en = 1'b0; blank = 1'b0; lamp_test = 1'b0;

    sweep[0]  = 8'hC0; sweep[1]  = 8'hF9; sweep[2]  = 8'hA4; sweep[3]  = 8'hB0;
    sweep[4]  = 8'h99; sweep[5]  = 8'h92; sweep[6]  = 8'h82; sweep[7]  = 8'hF8;
    sweep[8]  = 8'h80; sweep[9]  = 8'h90; sweep[10] = 8'hFF; sweep[11] = 8'hBF;
    sweep[12] = 8'h86; sweep[13] = 8'hAF; sweep[14] = 8'hA3; sweep[15] = 8'hFF;
    for (int i = 0; i < 16; i++) add(1'b0, 4'(i), 1'b0, 1'b0, 1'b0, sweep[i]);
    add(1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 8'h30);
    add(1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 8'h7F);
    add(1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'h7F);
    add(1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 8'h3F);
    add(1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 8'hFF);
    add(1'b0, 4'd5,  1'b1, 1'b1, 1'b1, 8'h00);
    add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 8'h00);
    add(1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 8'hF9);
    add(1'b0, 4'd8,  1'b1, 1'b0, 1'b0, 8'h00);
    add(1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 8'hFF);

    // Reset dominates lamp test; first edge after release shows lamp test.
    apply(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 8'hFF, 100);
    apply(1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 8'hFF, 101);
    apply(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 8'h00, 102);

    for (int i = 0; i < n_vec; i++) begin
      apply(tbl[i].rst, tbl[i].num, tbl[i].dp_en, tbl[i].blank, tbl[i].lamp_test,
            tbl[i].exp, i);
    end

    // Back-to-back codes with a one-edge reset pulse in the middle.
    apply(1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 8'hA4, 200);
    apply(1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 8'hF8, 201);
    apply(1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 8'hFF, 202);
    apply(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'hC0, 203);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d vectors still pending, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
